// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches one- and two-word instructions from a registered-read
//               IRAM and presents them with a valid/ready handshake.
//               Optional macro IFU_PERF_CNT_EN adds an accepted-instruction
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [15:0] START_ADDR = 16'd0,
  parameter logic [15:0] OP_ENDOP   = 16'd51
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] iram_addr,
  input  logic [15:0] iram_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_opcode,
  output logic [15:0] instr_operand,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  output logic [15:0] pc,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam logic [2:0] S_OP_REQ   = 3'd0;
  localparam logic [2:0] S_OP_CAP   = 3'd1;
  localparam logic [2:0] S_OPND_CAP = 3'd2;
  localparam logic [2:0] S_PRESENT  = 3'd3;
  localparam logic [2:0] S_HALT     = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_opcode;
  logic [15:0] r_operand;
  logic        w_two_word;
  logic        w_accept;

  // Opcodes that carry an operand word immediately after them.
  always_comb begin
    w_two_word = 1'b0;
    case (iram_data)
      16'd5, 16'd7, 16'd9, 16'd14, 16'd19,
      16'd24, 16'd46, 16'd48, 16'd62: w_two_word = 1'b1;
      default:                        w_two_word = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_PRESENT) && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_OP_REQ;
      r_pc      <= START_ADDR;
      r_opcode  <= 16'd0;
      r_operand <= 16'd0;
    end else begin
      case (r_state)
        S_OP_REQ: begin
          r_pc    <= r_pc + 16'd1;
          r_state <= S_OP_CAP;
        end
        S_OP_CAP: begin
          r_opcode  <= iram_data;
          r_operand <= 16'd0;
          if (w_two_word) begin
            r_pc    <= r_pc + 16'd1;
            r_state <= S_OPND_CAP;
          end else begin
            r_state <= S_PRESENT;
          end
        end
        S_OPND_CAP: begin
          r_operand <= iram_data;
          r_state   <= S_PRESENT;
        end
        S_PRESENT: begin
          if (instr_ready) begin
            // Redirect still applies on ENDOP; the halt only stops fetching.
            if (jump_en) begin
              r_pc <= jump_target;
            end
            r_state <= (r_opcode == OP_ENDOP) ? S_HALT : S_OP_REQ;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_OP_REQ;
        end
      endcase
    end
  end

  assign iram_addr     = r_pc;
  assign pc            = r_pc;
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_valid   = (r_state == S_PRESENT);
  assign halted        = (r_state == S_HALT);

`ifdef IFU_PERF_CNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_count <= 16'd0;
    end else if (w_accept && (r_instr_count != 16'hFFFF)) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter START_ADDR, default 16'd0, is the PC value loaded on reset.
REQ-002 Parameter OP_ENDOP, default 16'd51, is the opcode that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 iram_addr  output  16  instruction RAM read address; the IRAM returns the word one cycle later.
REQ-006 iram_data  input  16  instruction RAM registered read data.
REQ-007 instr_valid  output  1  instr_opcode and instr_operand hold a complete instruction.
REQ-008 instr_ready  input  1  core accepts the presented instruction this cycle.
REQ-009 instr_opcode  output  16  opcode word.
REQ-010 instr_operand  output  16  operand word; 16'd0 for one-word instructions.
REQ-011 jump_en  input  1  redirect request, qualified by acceptance.
REQ-012 jump_target  input  16  redirect address.
REQ-013 pc  output  16  address of the next word to fetch.
REQ-014 halted  output  1  ENDOP has been accepted; fetch has stopped.
REQ-015 instr_count  output  16  number of accepted instructions (see Configuration).

Function
REQ-016 iram_addr SHALL equal pc combinationally at all times.
REQ-017 The FSM SHALL have five states: OP_REQ, OP_CAP, OPND_CAP, PRESENT, HALT.
REQ-018 OP_REQ: pc <= pc+1; next state OP_CAP.
REQ-019 OP_CAP: latch iram_data into instr_opcode and clear instr_operand.
  - Two-word opcode: pc <= pc+1, next state OPND_CAP.
  - Otherwise: next state PRESENT.
REQ-020 Two-word opcodes SHALL be exactly 5, 7, 9, 14, 19, 24, 46, 48 and 62; all other values are one-word.
REQ-021 OPND_CAP: latch iram_data into instr_operand; next state PRESENT.
REQ-022 PRESENT: instr_valid = 1, and opcode/operand SHALL be held stable until instr_ready = 1.
REQ-023 Acceptance in PRESENT is instr_ready = 1 in that cycle.
  - With jump_en = 1: pc <= jump_target.
  - Next state: HALT if instr_opcode == OP_ENDOP, else OP_REQ.
REQ-024 jump_en SHALL be ignored in every cycle other than an accepting PRESENT cycle.
REQ-025 When an accepted ENDOP also has jump_en = 1, HALT SHALL win and pc SHALL still load jump_target.
REQ-026 HALT: instr_valid = 0, halted = 1, pc frozen; HALT SHALL be left only by rst.
REQ-027 instr_valid SHALL be 0 in every state except PRESENT.
REQ-028 pc arithmetic SHALL be modulo 2^16, so 16'hFFFF + 1 = 16'h0000, including between opcode and operand.
REQ-029 Latency from OP_REQ to instr_valid SHALL be 2 cycles for one-word and 3 cycles for two-word instructions.
REQ-030 Peak throughput SHALL be one instruction per 3 cycles (one-word) or per 4 cycles (two-word).

Reset
REQ-031 On rst = 1 at posedge clk, regardless of state (including mid-instruction or HALT), the block SHALL set:
  - pc = START_ADDR, state = OP_REQ;
  - instr_opcode = 0, instr_operand = 0, instr_valid = 0, halted = 0, instr_count = 0.
REQ-032 The first fetch SHALL issue iram_addr = START_ADDR in the first cycle after rst deasserts.

Configuration
REQ-033 Macro IFU_PERF_CNT_EN controls the instruction counter.
  - Defined: instr_count increments by 1 on every accepted instruction, including ENDOP, and saturates at 16'hFFFF.
  - Undefined: instr_count is tied to 16'd0 and no counter register exists.

Verification
REQ-034 IRAM = {0:LDAC, 1:7, 2:MVACR(29), 3:ENDOP}, ready held 1 -> three instructions in order:
  - (5,7) valid 3 cycles after rst release;
  - (29,0);
  - (51,0), then halted = 1 and pc = 4.
REQ-035 Opcode CLAC(35) presented with instr_ready = 0 for 5 cycles -> valid and opcode stay stable, pc unchanged; accepted on cycle 6.
REQ-036 JPNZ(48),operand 8 accepted with jump_en = 1 and jump_target = 8 -> next iram_addr = 8; with jump_en = 0 -> next iram_addr = 2.
REQ-037 START_ADDR = 16'hFFFF with word FFFF = LDAC and word 0 = 16'd9 -> operand fetched from address 0, instr = (5,9), pc = 1.
REQ-038 rst asserted in OPND_CAP and in HALT -> next cycle: state OP_REQ, instr_valid = 0, halted = 0, pc = START_ADDR.
REQ-039 With IFU_PERF_CNT_EN defined, after the REQ-034 program instr_count = 3; with it undefined, instr_count = 0 throughout.
